// File: rtl/mem_if_pkg.sv
// Shared definitions for the req/gnt/rvalid memory responder: FSM encoding,
// wait-counter width, default base address and word/byte-lane geometry.
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned CNT_W             = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0010_0000;
    localparam int unsigned WORD_W            = 32;
    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned NUM_BYTES         = WORD_W / BYTE_W;

endpackage

// File: rtl/responder_ram.sv
// Single-port DEPTH x 32 word RAM with per-byte write enables and registered
// read data. Contents and read register are intentionally not reset.
module responder_ram
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       en_i,
    input  logic                       we_i,
    input  logic [NUM_BYTES-1:0]       be_i,
    input  logic [$clog2(DEPTH)-1:0]   addr_i,
    input  logic [WORD_W-1:0]          wdata_i,
    output logic [WORD_W-1:0]          rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Read register only moves on reads so it survives intervening writes.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (be_i[k]) begin
                        mem_q[addr_i][k*BYTE_W +: BYTE_W] <= wdata_i[k*BYTE_W +: BYTE_W];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one grant per request, RAM access in the cycle before
// the single-cycle rvalid pulse, optional WAIT_CYCLES stretch between them.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        error_o
);

    localparam int unsigned      AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
    localparam logic [32:0]      LIMIT   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              inr_q, inr_d;
    logic [31:0]       rdata_hold_q, rdata_hold_d;
    logic              err_hold_q, err_hold_d;

    logic              in_range;
    logic              acc_now;
    logic              ram_en, ram_we;
    logic [3:0]        ram_be;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    assign gnt_o    = req_i && (state_q == ST_IDLE || state_q == ST_RESP);
    assign in_range = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            idx_q        <= '0;
            inr_q        <= 1'b0;
            rdata_hold_q <= '0;
            err_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            inr_q        <= inr_d;
            rdata_hold_q <= rdata_hold_d;
            err_hold_q   <= err_hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (gnt_o) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture on grant; the RAM is fed straight from the inputs when there is
    // no wait, otherwise from the captured request in the last WAIT cycle.
    always_comb begin
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        inr_d   = inr_q;
        if (gnt_o) begin
            we_d    = we_i;
            be_d    = be_i;
            wdata_d = wdata_i;
            idx_d   = addr_i[AW+1:2];
            inr_d   = in_range;
        end
        acc_now   = (gnt_o && WAIT_CYCLES == 0) || (state_q == ST_WAIT && cnt_q == CNT_W'(1));
        ram_en    = acc_now && inr_d;
        ram_we    = we_d;
        ram_be    = be_d;
        ram_addr  = idx_d;
        ram_wdata = wdata_d;
    end

    // Response fields are live only in RESP; elsewhere the last response is held.
    always_comb begin
        rvalid_o = (state_q == ST_RESP);
        rdata_o  = rdata_hold_q;
        error_o  = err_hold_q;
        if (rvalid_o) begin
            rdata_o = (!we_q && inr_q) ? ram_rdata : 32'h0;
            error_o = !inr_q;
        end
        rdata_hold_d = rdata_o;
        err_hold_d   = error_o;
    end

    responder_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder: two instances (WAIT 0 and 3)
// checked against a transaction-level word-array model with a response queue.
module tb_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req[2], we[2], gnt[2], rvalid[2], err[2];
    logic [3:0]  be[2];
    logic [31:0] addr[2], wdata[2], rdata[2];

    mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_n(reset_n), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .error_o(err[0]));

    mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset_n(reset_n), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .error_o(err[1]));

    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd[2];
    logic        last_er[2];
    logic        pend[2];
    int          wait_of[2] = '{0, 3};
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Initiator must hold req until granted.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset_n && pend[i]) assert (req[i]) else $error("protocol: req %0d dropped without gnt", i);
            pend[i] <= reset_n && req[i] && !gnt[i];
        end
    end

    // Response monitor: every rvalid must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                last_rd[i] = 32'h0;
                last_er[i] = 1'b0;
            end
        end else begin
            if (expq.size() > 0 && expq[0].due < cyc) begin
                chk("rvalid_missing", cyc, expq[0].due);
                void'(expq.pop_front());
            end
            for (int i = 0; i < 2; i++) begin
                if (rvalid[i]) begin
                    if (expq.size() == 0 || expq[0].inst != i) begin
                        chk("rvalid_spurious", 32'(i) + 32'h100, 32'(i));
                    end else begin
                        e = expq.pop_front();
                        chk("rvalid_cycle", cyc, e.due);
                        chk("rdata", rdata[i], e.rd);
                        chk("error", err[i], e.er);
                        last_rd[i] = e.rd;
                        last_er[i] = e.er;
                    end
                end else begin
                    chk("rdata_hold", rdata[i], last_rd[i]);
                    chk("error_hold", err[i], last_er[i]);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the grant with req dropped.
    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int waits);
        exp_t e;
        logic inr;
        int   idx;
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        waits = 0;
        #1;
        while (!gnt[i] && waits < 40) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!gnt[i]) begin
            chk("gnt_timeout", 32'(waits), 32'h0);
            req[i] = 1'b0;
            return;
        end
        inr = (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
        e.inst = i;
        e.due  = cyc + 1 + wait_of[i];
        e.rd   = 32'h0;
        e.er   = !inr;
        if (inr) begin
            idx = int'((a - BASE) >> 2);
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mdl[i][idx][8*k +: 8] = d[8*k +: 8];
            end else begin
                e.rd = mdl[i][idx];
            end
        end
        expq.push_back(e);
        @(negedge clk);
        req[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(expq.size()), 32'h0);
    endtask

    task automatic chk_outs_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_gnt"}, gnt[i], 1'b0);
            chk({tag, "_rvalid"}, rvalid[i], 1'b0);
            chk({tag, "_error"}, err[i], 1'b0);
            chk({tag, "_rdata"}, rdata[i], 32'h0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          wt;
        int          ii;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0; pend[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_outs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < DEPTH; w++)
                issue(i, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom, wt);
        drain();

        // Full word write then read at BASE.
        issue(0, 1'b1, BASE, 4'hF, 32'hDEADBEEF, wt);
        chk("t1_gnt_wait", 32'(wt), 32'h0);
        issue(0, 1'b0, BASE, 4'h0, 32'h0, wt);
        drain();

        // Partial byte lanes over DEADBEEF.
        issue(0, 1'b1, BASE, 4'b0101, 32'h11223344, wt);
        issue(0, 1'b0, BASE, 4'h0, 32'h0, wt);
        drain();

        // WAIT=3: second request is stalled for exactly the three WAIT cycles.
        issue(1, 1'b0, BASE + 32'd8, 4'h0, 32'h0, wt);
        issue(1, 1'b0, BASE + 32'd12, 4'h0, 32'h0, wt);
        chk("t3_gnt_gap", 32'(wt), 32'd3);
        drain();

        // Out-of-range accesses on both sides; word 0 must stay intact.
        for (int i = 0; i < 2; i++) begin
            issue(i, 1'b0, BASE - 32'd4, 4'h0, 32'h0, wt);
            issue(i, 1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0, wt);
            issue(i, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'h0BAD0BAD, wt);
            issue(i, 1'b0, BASE, 4'h0, 32'h0, wt);
        end
        drain();

        // Back-to-back write/read/read with no bubbles.
        a = BASE + 32'd20;
        issue(0, 1'b1, a, 4'hF, $urandom, wt);
        chk("t5_b2b_w", 32'(wt), 32'h0);
        issue(0, 1'b0, a, 4'h0, 32'h0, wt);
        chk("t5_b2b_r0", 32'(wt), 32'h0);
        issue(0, 1'b0, a + 32'd4, 4'h0, 32'h0, wt);
        chk("t5_b2b_r1", 32'(wt), 32'h0);
        drain();

        // Reset while a write sits in WAIT: no response, no commit.
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = BASE + 32'd20; be[1] = 4'hF; wdata[1] = 32'hCAFEF00D;
        #1;
        chk("t6_gnt", gnt[1], 1'b1);
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_outs_zero("t6_rst");
        repeat (2) @(negedge clk);
        chk_outs_zero("t6_rst_hold");
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(1, 1'b0, BASE + 32'd20, 4'h0, 32'h0, wt);
        chk("t6_first_gnt", 32'(wt), 32'h0);
        drain();

        // Randomized traffic, mostly in range, random gaps (0 gives back-to-back).
        for (int n = 0; n < 160; n++) begin
            ii = (n < 80) ? 0 : 1;
            a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0)
                a = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 4))
                                         : BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            a[1:0] = 2'($urandom);
            issue(ii, 1'($urandom), a, 4'($urandom), $urandom, wt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (n == 79) drain();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
